riscv_lbist_wrapper: RTL and testbench
======================================

RISCV_LBIST_WRAPPER -- requirements
Module: riscv_lbist_wrapper

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 Parameter INSTR_RDATA_WIDTH, default 128: core instruction fetch width; only 32 or 128 are legal.
REQ-003 Parameter RAM_ADDR_WIDTH, default 22: byte-address width of the RAM.
REQ-004 Parameter BOOT_ADDR, default 'h80: core boot address.
REQ-005 Parameter PULP_SECURE, default 0: passed to the core; the system bench sets it to 1.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 test_en  in  1  LBIST request; 0 selects functional mode.
REQ-009 fetch_enable_i  in  1  core fetch enable.
REQ-010 tests_passed_o  out  1  one-cycle pulse: pass word written.
REQ-011 tests_failed_o  out  1  one-cycle pulse: fail word written.
REQ-012 exit_valid_o  out  1  one-cycle pulse: exit word written.
REQ-013 exit_value_o  out  32  value of the last exit write.
REQ-014 bist_go  out  1  high while an LBIST run is in progress.
REQ-015 bist_end  out  1  sticky high once an LBIST run completes, until reset.

Function
REQ-016 The wrapper SHALL instantiate the existing riscv_core as riscv_core_i; its active-low core reset SHALL equal NOT(rst_i OR bist_go).
REQ-017 The wrapper SHALL instantiate the existing RAM as ram_i, with inner dual-port array ram_i.dp_ram_i.mem, so benches can $readmemh into it; port 0 SHALL serve instructions and port 1 SHALL serve data.
REQ-018 Internal nets data_req, data_we and data_addr SHALL exist at wrapper level, carrying the core LSU request, write enable and address.
REQ-019 Address decode for each data request SHALL be:
- 0x1000_0000 write: print the low byte as an ASCII character via $write;
- 0x2000_0000 write: 123456789 pulses tests_passed_o, 1 pulses tests_failed_o, any other value is ignored;
- 0x2000_0004 write: latch exit_value_o and pulse exit_valid_o;
- all other addresses: RAM, with the address truncated to RAM_ADDR_WIDTH.
REQ-020 Writes to peripheral addresses SHALL NOT modify RAM.
REQ-021 Peripheral reads SHALL return 0.
REQ-022 Every request SHALL be granted in the same cycle, with rvalid one cycle later.
REQ-023 The pass/fail/exit pulses SHALL occur in the cycle after the granted write.
REQ-024 LBIST state machine:
- IDLE -> RUN when test_en=1;
- RUN -> DONE after 1024 cycles;
- DONE -> IDLE only on reset.
REQ-025 During RUN:
- bist_go SHALL be 1;
- a 32-bit LFSR (polynomial x^32+x^22+x^2+x+1, seed 0xACE1_0001) SHALL advance once per cycle;
- a 32-bit MISR SHALL compress the core instr_addr each cycle.
REQ-026 In DONE, bist_go SHALL be 0 and bist_end SHALL be 1.
REQ-027 The final MISR value SHALL be readable by the bench as internal net bist_signature.
REQ-028 test_en deasserted mid-RUN SHALL NOT abort the run.

Reset
REQ-029 On rst_i=1 the following SHALL reset:
- tests_passed_o, tests_failed_o, exit_valid_o, bist_go, bist_end = 0;
- exit_value_o = 0;
- FSM = IDLE;
- LFSR = seed;
- MISR = 0.
REQ-030 RAM contents SHALL NOT be affected by reset.
REQ-031 Reset asserted mid-RUN SHALL return the FSM to IDLE with bist_end=0.

Structure
REQ-032 Package riscv_lbist_pkg SHALL hold:
- address constants PRINT_ADDR, TEST_ADDR, EXIT_ADDR;
- PASS_WORD = 123456789 and FAIL_WORD = 1;
- BIST_CYCLES = 1024;
- LFSR_SEED;
- the FSM state typedef.
REQ-033 The LBIST FSM, LFSR and MISR SHALL live in one sub-module, riscv_lbist_ctrl.

Verification
REQ-034 Firmware storing 123456789 to 0x2000_0000 -> tests_passed_o pulses for exactly one cycle.
REQ-035 Store of 1 to 0x2000_0000 -> tests_failed_o pulses; store of 5 to 0x2000_0004 -> exit_valid_o=1 with exit_value_o=5.
REQ-036 Store of 0x41 to 0x1000_0000 -> "A" printed and RAM unchanged.
REQ-037 test_en=1 for one cycle after reset:
- bist_go high for 1024 cycles;
- then bist_end=1 and bist_go=0;
- core held in reset for the whole run;
- identical bist_signature across two runs.
REQ-038 rst_i asserted at LBIST cycle 500 -> bist_go=0, bist_end=0 on the next clock.

Source files
------------

// File: rtl/riscv_lbist_pkg.sv
// riscv_lbist_pkg: shared constants, LBIST state type and LFSR/MISR step function
package riscv_lbist_pkg;
    localparam logic [31:0] PRINT_ADDR  = 32'h1000_0000;
    localparam logic [31:0] TEST_ADDR   = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
    localparam logic [31:0] PASS_WORD   = 32'd123456789;
    localparam logic [31:0] FAIL_WORD   = 32'd1;
    localparam int          BIST_CYCLES = 1024;
    localparam int          BIST_CNT_W  = $clog2(BIST_CYCLES);
    localparam logic [31:0] LFSR_SEED   = 32'hACE1_0001;

    typedef enum logic [1:0] {BIST_IDLE, BIST_RUN, BIST_DONE} bist_state_t;

    // Fibonacci step for x^32 + x^22 + x^2 + x + 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction
endpackage

// File: rtl/ram.sv
// ram: dual-port byte RAM, port a for instruction lines, port b for 32-bit data
module dp_ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk_i,
    input  logic                         en_a_i,
    input  logic [ADDR_WIDTH-1:0]        addr_a_i,
    output logic [INSTR_RDATA_WIDTH-1:0] rdata_a_o,
    input  logic                         en_b_i,
    input  logic [ADDR_WIDTH-1:0]        addr_b_i,
    input  logic                         we_b_i,
    input  logic [3:0]                   be_b_i,
    input  logic [31:0]                  wdata_b_i,
    output logic [31:0]                  rdata_b_o
);
    localparam int NB = INSTR_RDATA_WIDTH / 8;
    logic [7:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] base_a;
    assign base_a = addr_a_i & ~ADDR_WIDTH'(NB - 1);
    // instruction line read on port a, byte-enabled read/write on port b
    always_ff @(posedge clk_i) begin
        if (en_a_i)
            for (int i = 0; i < NB; i++) rdata_a_o[8*i +: 8] <= mem[base_a + ADDR_WIDTH'(i)];
        if (en_b_i)
            for (int i = 0; i < 4; i++) begin
                rdata_b_o[8*i +: 8] <= mem[addr_b_i + ADDR_WIDTH'(i)];
                if (we_b_i && be_b_i[i]) mem[addr_b_i + ADDR_WIDTH'(i)] <= wdata_b_i[8*i +: 8];
            end
    end
endmodule

// ram: grants every request at once and returns read data one cycle later
module ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_req_i,
    input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
    input  logic                         data_req_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o
);
    assign instr_gnt_o = instr_req_i;
    assign data_gnt_o  = data_req_i;

    dp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) dp_ram_i (
        .clk_i     (clk_i),
        .en_a_i    (instr_req_i),
        .addr_a_i  (instr_addr_i),
        .rdata_a_o (instr_rdata_o),
        .en_b_i    (data_req_i),
        .addr_b_i  (data_addr_i),
        .we_b_i    (data_we_i),
        .be_b_i    (data_be_i),
        .wdata_b_i (data_wdata_i),
        .rdata_b_o (data_rdata_o)
    );

    // read-valid follows each granted request by one cycle; contents are never reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
        end else begin
            instr_rvalid_o <= instr_req_i;
            data_rvalid_o  <= data_req_i;
        end
    end
endmodule

// File: rtl/riscv_core.sv
// riscv_core: small multi-cycle RV32I subset core (LUI, ADDI, LW, SW, JAL)
module riscv_core #(
    parameter int INSTR_RDATA_WIDTH = 128,
    parameter bit PULP_SECURE       = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         fetch_enable_i,
    input  logic [31:0]                  boot_addr_i,
    output logic                         instr_req_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    output logic [31:0]                  instr_addr_o,
    input  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_addr_o,
    output logic [31:0]                  data_wdata_o,
    input  logic [31:0]                  data_rdata_i
);
    typedef enum logic [1:0] {C_FETCH, C_WAIT, C_EXEC, C_MEM} core_state_t;
    core_state_t state, state_n;
    logic [31:0] pc, ir, rf [32];
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_u, imm_j;
    logic [1:0]  wsel;
    logic        is_lui, is_addi, is_lw, is_sw, is_jal, illegal, retire;

    assign wsel    = (INSTR_RDATA_WIDTH == 128) ? pc[3:2] : 2'd0;
    assign rs1_v   = (ir[19:15] == 5'd0) ? 32'd0 : rf[ir[19:15]];
    assign rs2_v   = (ir[24:20] == 5'd0) ? 32'd0 : rf[ir[24:20]];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_u   = {ir[31:12], 12'd0};
    assign imm_j   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign is_lui  = ir[6:0] == 7'h37;
    assign is_addi = ir[6:0] == 7'h13 && ir[14:12] == 3'd0;
    assign is_lw   = ir[6:0] == 7'h03 && ir[14:12] == 3'd2;
    assign is_sw   = ir[6:0] == 7'h23 && ir[14:12] == 3'd2;
    assign is_jal  = ir[6:0] == 7'h6F;
    assign illegal = !(is_lui || is_addi || is_lw || is_sw || is_jal);

    assign instr_req_o  = state == C_FETCH && fetch_enable_i;
    assign instr_addr_o = pc;
    assign data_req_o   = state == C_EXEC && (is_lw || is_sw);
    assign data_we_o    = is_sw;
    assign data_be_o    = 4'hF;
    assign data_addr_o  = rs1_v + (is_sw ? imm_s : imm_i);
    assign data_wdata_o = rs2_v;
    assign retire       = state == C_EXEC && !data_req_o;

    // fetch -> wait for line -> execute -> optional memory wait
    always_comb begin
        state_n = state;
        case (state)
            C_FETCH: state_n = instr_req_o && instr_gnt_i ? C_WAIT : C_FETCH;
            C_WAIT:  state_n = instr_rvalid_i ? C_EXEC : C_WAIT;
            C_EXEC:  state_n = !data_req_o ? C_FETCH : data_gnt_i ? C_MEM : C_EXEC;
            default: state_n = data_rvalid_i ? C_FETCH : C_MEM;
        endcase
    end

    // pc and instruction register; illegal opcodes restart at boot when secure
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= C_FETCH;
            pc    <= boot_addr_i;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == C_WAIT && instr_rvalid_i) ir <= instr_rdata_i[32*wsel +: 32];
            if (retire) pc <= is_jal ? pc + imm_j : (illegal && PULP_SECURE) ? boot_addr_i : pc + 32'd4;
            if (state == C_MEM && data_rvalid_i) pc <= pc + 32'd4;
        end
    end

    // register file writeback; x0 is never written
    always_ff @(posedge clk_i) begin
        if (rst_ni && retire && (is_lui || is_addi || is_jal) && ir[11:7] != 5'd0)
            rf[ir[11:7]] <= is_lui ? imm_u : is_addi ? rs1_v + imm_i : pc + 32'd4;
        if (rst_ni && state == C_MEM && data_rvalid_i && is_lw && ir[11:7] != 5'd0)
            rf[ir[11:7]] <= data_rdata_i;
    end
endmodule

// File: rtl/riscv_lbist_ctrl.sv
// riscv_lbist_ctrl: LBIST sequencer with pattern LFSR and signature MISR
module riscv_lbist_ctrl
    import riscv_lbist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        test_en,
    input  logic [31:0] instr_addr,
    output logic        bist_go,
    output logic        bist_end,
    output logic [31:0] bist_signature
);
    bist_state_t state, state_n;
    logic [BIST_CNT_W-1:0] cnt;
    logic [31:0] lfsr, misr;

    // a run starts on request and always completes; only reset leaves DONE
    always_comb begin
        state_n = state;
        state_n = (state == BIST_IDLE && test_en) ? BIST_RUN
                : (state == BIST_RUN && cnt == BIST_CNT_W'(BIST_CYCLES - 1)) ? BIST_DONE : state;
    end

    // state, cycle counter, LFSR and MISR; the pattern is folded into the signature too
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= BIST_IDLE;
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
            misr  <= '0;
        end else begin
            state <= state_n;
            if (state == BIST_RUN) begin
                cnt  <= cnt + 1'b1;
                lfsr <= lfsr_step(lfsr);
                misr <= lfsr_step(misr) ^ instr_addr ^ lfsr;
            end
        end
    end

    assign bist_go        = state == BIST_RUN;
    assign bist_end       = state == BIST_DONE;
    assign bist_signature = misr;
endmodule

// File: rtl/riscv_lbist_wrapper.sv
// riscv_lbist_wrapper: core + RAM + memory-mapped test peripherals + LBIST control
module riscv_lbist_wrapper
    import riscv_lbist_pkg::*;
#(
    parameter int          INSTR_RDATA_WIDTH = 128,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 'h80,
    parameter bit          PULP_SECURE       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        test_en,
    input  logic        fetch_enable_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        bist_go,
    output logic        bist_end
);
    logic                         core_rst_n, instr_req, instr_gnt, instr_rvalid;
    logic [31:0]                  instr_addr;
    logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;
    logic                         data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]                   data_be;
    logic [31:0]                  data_addr, data_wdata, data_rdata, ram_rdata, bist_signature;
    logic                         is_print, is_test, is_exit, is_periph, periph_q, wr_test;

    assign core_rst_n = !(rst_i || bist_go);
    assign is_print   = data_addr == PRINT_ADDR;
    assign is_test    = data_addr == TEST_ADDR;
    assign is_exit    = data_addr == EXIT_ADDR;
    assign is_periph  = is_print || is_test || is_exit;
    assign wr_test    = data_req && data_we && is_test;
    assign data_rdata = periph_q ? 32'd0 : ram_rdata;

    riscv_core #(.INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH), .PULP_SECURE(PULP_SECURE)) riscv_core_i (
        .clk_i          (clk_i),
        .rst_ni         (core_rst_n),
        .fetch_enable_i (fetch_enable_i),
        .boot_addr_i    (BOOT_ADDR),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_addr_o   (instr_addr),
        .instr_rdata_i  (instr_rdata),
        .data_req_o     (data_req),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_we_o      (data_we),
        .data_be_o      (data_be),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_rdata_i   (data_rdata)
    );

    ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) ram_i (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr[RAM_ADDR_WIDTH-1:0]),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr[RAM_ADDR_WIDTH-1:0]),
        .data_we_i      (data_we && !is_periph),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (ram_rdata)
    );

    riscv_lbist_ctrl lbist_ctrl_i (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .test_en        (test_en),
        .instr_addr     (instr_addr),
        .bist_go        (bist_go),
        .bist_end       (bist_end),
        .bist_signature (bist_signature)
    );

    // peripheral write pulses land the cycle after the granted store
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            periph_q       <= 1'b0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            periph_q       <= data_req && is_periph;
            tests_passed_o <= wr_test && data_wdata == PASS_WORD;
            tests_failed_o <= wr_test && data_wdata == FAIL_WORD;
            exit_valid_o   <= data_req && data_we && is_exit;
            if (data_req && data_we && is_exit) exit_value_o <= data_wdata;
        end
    end

`ifndef SYNTHESIS
    // console character output for firmware
    always_ff @(posedge clk_i) begin
        if (!rst_i && data_req && data_we && is_print) $write("%c", data_wdata[7:0]);
    end
`endif
endmodule

// File: tb/tb_riscv_lbist_wrapper.sv
// tb_riscv_lbist_wrapper: directed firmware and LBIST checks for riscv_lbist_wrapper
module tb_riscv_lbist_wrapper;
    logic        clk_i = 1'b0, rst_i = 1'b1, test_en = 1'b0, fetch_enable_i = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o, bist_go, bist_end;
    logic [31:0] exit_value_o;
    int          checks = 0, errors = 0;

    localparam logic [31:0] PROG [17] = '{
        32'h200000B7, 32'h075BD137, 32'hD1510113, 32'h0020A023,
        32'h00100193, 32'h0030A023, 32'h00500213, 32'h0040A223,
        32'h100002B7, 32'h04100313, 32'h0062A023, 32'h00700393,
        32'h0070A023, 32'h0000A403, 32'h10802023, 32'h12300493,
        32'h10902223};

    riscv_lbist_wrapper #(.RAM_ADDR_WIDTH(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .test_en        (test_en),
        .fetch_enable_i (fetch_enable_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o),
        .bist_go        (bist_go),
        .bist_end       (bist_end)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_word(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) dut.ram_i.dp_ram_i.mem[a + 16'(i)] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] get_word(input logic [15:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = dut.ram_i.dp_ram_i.mem[a + 16'(i)];
        return w;
    endfunction

    task automatic run_bist(output int go_cycles, output int core_bad);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        test_en = 1'b1;
        @(negedge clk_i);
        test_en = 1'b0;
        go_cycles = 0;
        core_bad = 0;
        while (bist_go && go_cycles < 2000) begin
            go_cycles++;
            if (dut.riscv_core_i.rst_ni !== 1'b0) core_bad++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        int n_pass, n_fail, n_exit, wide, late, go_n, bad;
        logic p_prev, f_prev, e_prev, exit_wr_prev, pass_wr_prev;
        logic [31:0] sig1;
        put_word(16'h0000, 32'hDEADBEEF);
        put_word(16'h0004, 32'hCAFEF00D);
        put_word(16'h0100, 32'hFFFFFFFF);
        put_word(16'h0104, 32'h00000000);
        for (int i = 0; i < 17; i++) put_word(16'h0080 + 16'(4 * i), PROG[i]);
        put_word(16'h00C4, 32'h0000006F);
        repeat (3) @(negedge clk_i);
        check("rst_passed", 32'(tests_passed_o), 32'd0);
        check("rst_failed", 32'(tests_failed_o), 32'd0);
        check("rst_exit_valid", 32'(exit_valid_o), 32'd0);
        check("rst_exit_value", exit_value_o, 32'd0);
        check("rst_bist_go", 32'(bist_go), 32'd0);
        check("rst_bist_end", 32'(bist_end), 32'd0);
        check("rst_signature", dut.bist_signature, 32'd0);

        rst_i = 1'b0;
        fetch_enable_i = 1'b1;
        {n_pass, n_fail, n_exit, wide, late} = '0;
        {p_prev, f_prev, e_prev, exit_wr_prev, pass_wr_prev} = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            n_pass += int'(tests_passed_o);
            n_fail += int'(tests_failed_o);
            n_exit += int'(exit_valid_o);
            if ((tests_passed_o && p_prev) || (tests_failed_o && f_prev) || (exit_valid_o && e_prev)) wide++;
            if (exit_valid_o !== exit_wr_prev || tests_passed_o !== pass_wr_prev) late++;
            {p_prev, f_prev, e_prev} = {tests_passed_o, tests_failed_o, exit_valid_o};
            exit_wr_prev = dut.data_req && dut.data_we && dut.data_addr == 32'h2000_0004;
            pass_wr_prev = dut.data_req && dut.data_we && dut.data_addr == 32'h2000_0000 && dut.data_wdata == 32'd123456789;
        end
        fetch_enable_i = 1'b0;
        $display("");
        check("pass_pulses", 32'(n_pass), 32'd1);
        check("fail_pulses", 32'(n_fail), 32'd1);
        check("exit_pulses", 32'(n_exit), 32'd1);
        check("pulse_width", 32'(wide), 32'd0);
        check("pulse_timing", 32'(late), 32'd0);
        check("exit_value", exit_value_o, 32'd5);
        check("ram_word0_kept", get_word(16'h0000), 32'hDEADBEEF);
        check("ram_word4_kept", get_word(16'h0004), 32'hCAFEF00D);
        check("periph_read_zero", get_word(16'h0100), 32'd0);
        check("ram_store", get_word(16'h0104), 32'h00000123);

        run_bist(go_n, bad);
        check("bist_go_cycles", 32'(go_n), 32'd1024);
        check("core_held_reset", 32'(bad), 32'd0);
        check("done_bist_go", 32'(bist_go), 32'd0);
        check("done_bist_end", 32'(bist_end), 32'd1);
        sig1 = dut.bist_signature;
        check("sig_nonzero", 32'(sig1 != 32'd0), 32'd1);
        test_en = 1'b1;
        repeat (5) @(negedge clk_i);
        test_en = 1'b0;
        check("done_no_restart", 32'(bist_go), 32'd0);
        check("done_sticky", 32'(bist_end), 32'd1);

        run_bist(go_n, bad);
        check("bist_go_cycles_2", 32'(go_n), 32'd1024);
        check("sig_repeat", dut.bist_signature, sig1);

        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        test_en = 1'b1;
        @(negedge clk_i);
        test_en = 1'b0;
        repeat (500) @(negedge clk_i);
        check("midrun_go", 32'(bist_go), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_bist_go", 32'(bist_go), 32'd0);
        check("abort_bist_end", 32'(bist_end), 32'd0);
        check("abort_signature", dut.bist_signature, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_after_abort", 32'(bist_go), 32'd0);
        check("ram_survives_reset", get_word(16'h0104), 32'h00000123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
